// File: rtl/run_ctrl_pkg.sv
// Shared types for the core run/halt sequencer: host command codes, sequencer
// states, halt causes and the EBREAK encoding.
package run_ctrl_pkg;

  typedef enum logic [1:0] {
    CMD_RUN  = 2'd0,
    CMD_HALT = 2'd1,
    CMD_STEP = 2'd2,
    CMD_CLR  = 2'd3
  } cmd_op_t;

  typedef enum logic [1:0] {
    ST_HALTED  = 2'd0,
    ST_RUNNING = 2'd1,
    ST_STEP    = 2'd2
  } run_state_t;

  typedef enum logic [2:0] {
    CAUSE_NONE   = 3'd0,
    CAUSE_HOST   = 3'd1,
    CAUSE_BP     = 3'd2,
    CAUSE_EBREAK = 3'd3,
    CAUSE_STEP   = 3'd4
  } halt_cause_t;

  localparam logic [31:0] EBREAK_INSN = 32'h00100073;

endpackage

// File: rtl/run_ctrl_stop_detect.sv
// Combinational stop detector: PC breakpoint and EBREAK match, masked by skip.
// The breakpoint comparator exists only when RUN_CTRL_BP_EN is defined.
module run_ctrl_stop_detect
  import run_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] pc_i,
  input  logic [31:0]     instruction_i,
  input  logic            bp_en_i,
  input  logic [XLEN-1:0] bp_addr_i,
  input  logic            skip_i,
  output logic            stop_o,
  output halt_cause_t     cause_o
);

  logic ebreak_hit;
  logic bp_hit;

  assign ebreak_hit = (instruction_i == EBREAK_INSN);

`ifdef RUN_CTRL_BP_EN
  assign bp_hit = bp_en_i & (pc_i == bp_addr_i);
`else
  logic unused_bp;
  assign unused_bp = ^{bp_en_i, bp_addr_i, pc_i};
  assign bp_hit    = 1'b0;
`endif

  assign stop_o  = (bp_hit | ebreak_hit) & ~skip_i;
  // Breakpoint takes priority when both match the same instruction.
  assign cause_o = bp_hit ? CAUSE_BP : CAUSE_EBREAK;

endmodule

// File: rtl/core_run_ctrl.sv
// Run/halt/step sequencer gating architectural commits of the single-cycle core.
// Optional breakpoint comparator enabled by defining RUN_CTRL_BP_EN.
module core_run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int CNT_W       = 32,
  parameter bit BOOT_HALTED = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  // Command handshake: a command transfers on a rising edge where
  // cmd_valid & cmd_ready; cmd_op must be stable while cmd_valid is high.
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [XLEN-1:0]  pc,
  input  logic [31:0]      instruction,
  input  logic             bp_en,
  input  logic [XLEN-1:0]  bp_addr,
  output logic             core_en,
  output logic             halted,
  output logic [2:0]       halt_cause,
  output logic             step_done,
  output logic [CNT_W-1:0] retire_cnt
);

  localparam run_state_t RESET_STATE = BOOT_HALTED ? ST_HALTED : ST_RUNNING;

  run_state_t       state_q, state_d;
  halt_cause_t      cause_q, cause_d;
  logic             skip_q, skip_d;
  logic             step_done_q, step_done_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic        stop;
  halt_cause_t stop_cause;
  logic        cmd_fire;
  cmd_op_t     op;

  run_ctrl_stop_detect #(.XLEN(XLEN)) u_stop_detect (
    .pc_i          (pc),
    .instruction_i (instruction),
    .bp_en_i       (bp_en),
    .bp_addr_i     (bp_addr),
    .skip_i        (skip_q),
    .stop_o        (stop),
    .cause_o       (stop_cause)
  );

  assign op        = cmd_op_t'(cmd_op);
  // Reset gates commit and the handshake directly so nothing leaks while low.
  assign core_en   = reset & (state_q != ST_HALTED) & ~stop;
  assign cmd_ready = reset & (state_q != ST_STEP);
  assign cmd_fire  = cmd_valid & cmd_ready;

  assign halted     = (state_q == ST_HALTED);
  assign halt_cause = cause_q;
  assign step_done  = step_done_q;
  assign retire_cnt = cnt_q;

  always_comb begin
    state_d     = state_q;
    cause_d     = cause_q;
    skip_d      = skip_q;
    step_done_d = (state_q == ST_STEP) & core_en;
    cnt_d       = cnt_q + {{(CNT_W-1){1'b0}}, core_en};
    if (core_en) skip_d = 1'b0;

    case (state_q)
      ST_HALTED: begin
        if (cmd_fire) begin
          case (op)
            CMD_RUN: begin
              state_d = ST_RUNNING;
              skip_d  = 1'b1;
              cause_d = CAUSE_NONE;
            end
            CMD_STEP: begin
              state_d = ST_STEP;
              skip_d  = 1'b1;
              cause_d = CAUSE_NONE;
            end
            CMD_CLR: cnt_d = '0;
            default: ;
          endcase
        end
      end
      ST_RUNNING: begin
        if (stop) begin
          state_d = ST_HALTED;
          cause_d = stop_cause;
        end else if (cmd_fire && op == CMD_HALT) begin
          state_d = ST_HALTED;
          cause_d = CAUSE_HOST;
        end
      end
      ST_STEP: begin
        state_d = ST_HALTED;
        cause_d = core_en ? CAUSE_STEP : stop_cause;
      end
      default: state_d = RESET_STATE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= RESET_STATE;
      cause_q     <= CAUSE_NONE;
      skip_q      <= 1'b0;
      step_done_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      cause_q     <= cause_d;
      skip_q      <= skip_d;
      step_done_q <= step_done_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: tb/tb_core_run_ctrl.sv
// Bench for core_run_ctrl: directed host sequences against a behavioural model
// of the run/halt rules, plus literal pins for the key scenarios.
module tb_core_run_ctrl;

  localparam int CNT_W = 4;
  localparam logic [31:0] EBREAK = 32'h00100073;
  localparam logic [31:0] NOP    = 32'h00000013;
`ifdef RUN_CTRL_BP_EN
  localparam bit BP = 1'b1;
`else
  localparam bit BP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             cmd_valid = 1'b0;
  logic [1:0]       cmd_op = 2'd0;
  logic [31:0]      pc = 32'h0;
  logic [31:0]      instruction = NOP;
  logic             bp_en = 1'b0;
  logic [31:0]      bp_addr = 32'h0;
  logic             cmd_ready, core_en, halted, step_done;
  logic [2:0]       halt_cause;
  logic [CNT_W-1:0] retire_cnt;
  logic             b_cmd_ready, b_core_en, b_halted, b_step_done;
  logic [2:0]       b_halt_cause;
  logic [31:0]      b_retire_cnt;

  logic [31:0] ebreak_addr = 32'hFFFF_FF00;
  int checks = 0;
  int errors = 0;

  // clock / reset
  always #5 clk = ~clk;

  core_run_ctrl #(.XLEN(32), .CNT_W(CNT_W), .BOOT_HALTED(1'b1)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .pc(pc), .instruction(instruction), .bp_en(bp_en),
    .bp_addr(bp_addr), .core_en(core_en), .halted(halted),
    .halt_cause(halt_cause), .step_done(step_done), .retire_cnt(retire_cnt)
  );

  core_run_ctrl #(.XLEN(32), .CNT_W(32), .BOOT_HALTED(1'b0)) dut_b (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(b_cmd_ready),
    .cmd_op(cmd_op), .pc(pc), .instruction(instruction), .bp_en(bp_en),
    .bp_addr(bp_addr), .core_en(b_core_en), .halted(b_halted),
    .halt_cause(b_halt_cause), .step_done(b_step_done), .retire_cnt(b_retire_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model: mode flags, skip, cause, pulse and a modulo counter
  bit m_halted = 1'b1;
  bit m_run    = 1'b0;
  bit m_step   = 1'b0;
  bit m_skip   = 1'b0;
  bit m_pulse  = 1'b0;
  int m_cause  = 0;
  int m_cnt    = 0;

  function automatic bit m_bp_hit();
    return BP && bp_en && (pc == bp_addr);
  endfunction

  function automatic bit m_stop();
    return (m_bp_hit() || instruction == EBREAK) && !m_skip;
  endfunction

  function automatic bit exp_core_en();
    return reset && (m_run || m_step) && !m_stop();
  endfunction

  function automatic logic [31:0] insn_at(input logic [31:0] a);
    return (a == ebreak_addr) ? EBREAK : NOP;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_halted <= 1'b1; m_run <= 1'b0; m_step <= 1'b0; m_skip <= 1'b0;
      m_pulse <= 1'b0; m_cause <= 0; m_cnt <= 0;
    end else begin
      m_pulse <= m_step && exp_core_en();
      if (exp_core_en()) begin
        m_cnt  <= (m_cnt + 1) % (1 << CNT_W);
        m_skip <= 1'b0;
      end
      if (m_halted) begin
        if (cmd_valid) begin
          case (cmd_op)
            2'd0: begin m_halted <= 1'b0; m_run <= 1'b1; m_skip <= 1'b1; m_cause <= 0; end
            2'd2: begin m_halted <= 1'b0; m_step <= 1'b1; m_skip <= 1'b1; m_cause <= 0; end
            2'd3: m_cnt <= 0;
            default: ;
          endcase
        end
      end else if (m_run) begin
        if (m_stop()) begin
          m_run <= 1'b0; m_halted <= 1'b1; m_cause <= m_bp_hit() ? 2 : 3;
        end else if (cmd_valid && cmd_op == 2'd1) begin
          m_run <= 1'b0; m_halted <= 1'b1; m_cause <= 1;
        end
      end else begin
        m_step <= 1'b0; m_halted <= 1'b1;
        m_cause <= exp_core_en() ? 4 : (m_bp_hit() ? 2 : 3);
      end
    end
  end

  // scoreboard compare, every cycle on the falling edge
  always @(negedge clk) begin
    chk("core_en",    {31'b0, core_en},    {31'b0, exp_core_en()});
    chk("halted",     {31'b0, halted},     {31'b0, m_halted});
    chk("cmd_ready",  {31'b0, cmd_ready},  {31'b0, reset && !m_step});
    chk("halt_cause", {29'b0, halt_cause}, m_cause);
    chk("step_done",  {31'b0, step_done},  {31'b0, m_pulse});
    chk("retire_cnt", {28'b0, retire_cnt}, m_cnt);
  end

  // driver: a fake core advancing PC by 4 on every expected commit
  task automatic tick();
    bit en;
    en = exp_core_en();
    @(posedge clk);
    #1;
    if (en) pc = pc + 32'd4;
    instruction = insn_at(pc);
  endtask

  task automatic cmd(input logic [1:0] op);
    cmd_valid = 1'b1;
    cmd_op    = op;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic set_pc(input logic [31:0] a);
    pc = a;
    instruction = insn_at(a);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_core_en", {31'b0, core_en}, 32'd0);
    chk("rst_halted", {31'b0, halted}, 32'd1);
    chk("rst_ready", {31'b0, cmd_ready}, 32'd0);
    chk("rst_cause", {29'b0, halt_cause}, 32'd0);
    chk("rst_cnt", {28'b0, retire_cnt}, 32'd0);
    chk("b_rst_halted", {31'b0, b_halted}, 32'd0);
    chk("b_rst_core_en", {31'b0, b_core_en}, 32'd0);
    chk("b_rst_ready", {31'b0, b_cmd_ready}, 32'd0);
    #1 reset = 1'b1;
    tick(); #1;
    chk("boot_halted", {31'b0, halted}, 32'd1);
    chk("boot_core_en", {31'b0, core_en}, 32'd0);
    chk("boot_ready", {31'b0, cmd_ready}, 32'd1);
    chk("b_boot_run", {31'b0, b_core_en}, 32'd1);
    chk("b_boot_halted", {31'b0, b_halted}, 32'd0);

    // single step from boot
    cmd(2'd2); #1;
    chk("step_core_en", {31'b0, core_en}, 32'd1);
    chk("step_ready", {31'b0, cmd_ready}, 32'd0);
    tick(); #1;
    chk("step_cause", {29'b0, halt_cause}, 32'd4);
    chk("step_done", {31'b0, step_done}, 32'd1);
    chk("step_cnt", {28'b0, retire_cnt}, 32'd1);
    tick(); #1;
    chk("step_done_low", {31'b0, step_done}, 32'd0);

    // breakpoint at 0x10 from pc 4
    bp_en = 1'b1; bp_addr = 32'h10;
    cmd(2'd0);
    repeat (3) tick();
    #1;
    chk("bp_core_en", {31'b0, core_en}, BP ? 32'd0 : 32'd1);
    tick(); #1;
    chk("bp_halted", {31'b0, halted}, BP ? 32'd1 : 32'd0);
    chk("bp_cause", {29'b0, halt_cause}, BP ? 32'd2 : 32'd0);
    chk("bp_cnt", {28'b0, retire_cnt}, BP ? 32'd4 : 32'd5);
    cmd(2'd1);
    set_pc(32'h10);
    cmd(2'd0); #1;
    chk("bp_resume_en", {31'b0, core_en}, 32'd1);
    tick(); tick(); #1;
    chk("bp_no_rehalt", {31'b0, halted}, 32'd0);
    cmd(2'd1); #1;
    chk("host_cause", {29'b0, halt_cause}, 32'd1);

    // EBREAK at 0x24
    bp_en = 1'b0; ebreak_addr = 32'h24;
    set_pc(32'h1C);
    cmd(2'd0);
    tick(); tick(); #1;
    chk("ebreak_core_en", {31'b0, core_en}, 32'd0);
    tick(); #1;
    chk("ebreak_cause", {29'b0, halt_cause}, 32'd3);
    cmd(2'd2); #1;
    chk("ebreak_step_en", {31'b0, core_en}, 32'd1);
    tick(); #1;
    chk("ebreak_step_cause", {29'b0, halt_cause}, 32'd4);
    tick();

    // host HALT colliding with a breakpoint
    bp_en = 1'b1; bp_addr = 32'h34;
    set_pc(32'h2C);
    cmd(2'd0);
    tick(); tick();
    cmd_valid = 1'b1; cmd_op = 2'd1; #1;
    chk("coll_core_en", {31'b0, core_en}, BP ? 32'd0 : 32'd1);
    chk("coll_ready", {31'b0, cmd_ready}, 32'd1);
    tick();
    cmd_valid = 1'b0; #1;
    chk("coll_cause", {29'b0, halt_cause}, BP ? 32'd2 : 32'd1);

    // CLR semantics and counter wrap
    bp_en = 1'b0;
    set_pc(32'h40);
    cmd(2'd0);
    tick();
    cmd(2'd3);
    tick(); #1;
    chk("clr_run_ignored", {31'b0, (retire_cnt != 0)}, 32'd1);
    cmd(2'd1);
    cmd(2'd3); #1;
    chk("clr_halted", {28'b0, retire_cnt}, 32'd0);
    cmd(2'd0);
    repeat (15) tick();
    #1;
    chk("cnt_15", {28'b0, retire_cnt}, 32'd15);
    cmd(2'd1); #1;
    chk("cnt_wrap", {28'b0, retire_cnt}, 32'd0);
    chk("wrap_halted", {31'b0, halted}, 32'd1);

    // asynchronous reset during a step
    tick();
    cmd(2'd2); #1;
    chk("pre_rst_en", {31'b0, core_en}, 32'd1);
    reset = 1'b0; #1;
    chk("arst_core_en", {31'b0, core_en}, 32'd0);
    chk("arst_halted", {31'b0, halted}, 32'd1);
    chk("arst_ready", {31'b0, cmd_ready}, 32'd0);
    chk("arst_cause", {29'b0, halt_cause}, 32'd0);
    chk("arst_step_done", {31'b0, step_done}, 32'd0);
    tick(); tick();
    reset = 1'b1;
    tick(); tick(); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/core_run_ctrl.md
# core_run_ctrl

Run/halt sequencer for the single-cycle RISC-V core. Generates the core's architectural-update enable (`core_en`, which gates PC, register-file and data-memory writes), accepts host run/halt/step commands over a valid/ready handshake, and halts on a PC breakpoint or on `EBREAK`. Sits between the host or debug port and the `SingleCycle` top, and keeps a retired-instruction counter.

## Interface
Parameters:
- `XLEN`, 32, width of PC and breakpoint address
- `CNT_W`, 32, retired-instruction counter width
- `BOOT_HALTED`, 0, 1 = leave reset in HALTED, 0 = leave reset in RUNNING

Ports:
- `clk`  in  1  core clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `cmd_valid`  in  1  host command valid
- `cmd_ready`  out  1  command accepted when `cmd_valid & cmd_ready`
- `cmd_op`  in  2  0 RUN, 1 HALT, 2 STEP, 3 CLR
- `pc`  in  XLEN  current core PC
- `instruction`  in  32  instruction currently fetched
- `bp_en`  in  1  breakpoint enable
- `bp_addr`  in  XLEN  breakpoint PC
- `core_en`  out  1  core may commit this cycle
- `halted`  out  1  state is HALTED
- `halt_cause`  out  3  0 NONE, 1 HOST, 2 BP, 3 EBREAK, 4 STEP
- `step_done`  out  1  one-cycle pulse after a step commits
- `retire_cnt`  out  CNT_W  count of cycles with `core_en=1`

## Operation
- States are HALTED, RUNNING and STEP.
- The registered `skip` flag masks the breakpoint and EBREAK checks.
- `stop = (bp_en & pc==bp_addr | instruction==32'h00100073) & ~skip`.
- `core_en = (RUNNING | STEP) & ~stop`. This is combinational from `pc` and `instruction`.
- HALTED:
  - RUN → RUNNING; STEP → STEP. Both set `skip` and clear `halt_cause`.
  - CLR zeroes `retire_cnt`. HALT is a no-op.
- RUNNING:
  - If `stop`: → HALTED with cause BP (2) or EBREAK (3). BP wins if both hold.
  - Otherwise, HALT → HALTED with cause HOST (1). The instruction in the accept cycle still commits.
  - RUN, STEP and CLR are accepted and ignored.
- STEP (exactly one cycle):
  - If `core_en`: → HALTED with cause STEP (4), and `step_done` pulses in the next cycle.
  - If `stop`: → HALTED with cause BP or EBREAK, and `step_done` stays 0.
- `skip` clears on the first cycle with `core_en=1`. Resuming from a breakpoint or EBREAK therefore executes that instruction once. EBREAK advances PC like a NOP.
- `cmd_ready = 0` in STEP and 1 otherwise.
- A host HALT and `stop` in the same cycle: `stop` wins the cause, and the command is consumed.
- `retire_cnt` increments modulo 2^CNT_W on each `core_en=1` cycle. CLR outside HALTED is accepted and ignored.

## Timing
- While `reset` is low:
  - state = BOOT_HALTED ? HALTED : RUNNING, but `core_en=0`
  - `halted=BOOT_HALTED`, `halt_cause=0`, `skip=0`, `retire_cnt=0`, `step_done=0`, `cmd_ready=0`
- Reset mid-step or mid-run aborts immediately and asynchronously. No commit occurs while `reset` is low.
- Command-to-effect latency is one edge. For example, RUN is accepted at edge N and `core_en=1` in cycle N+1.
- Breakpoint response is zero cycles: `core_en=0` in the same cycle that PC matches, and `halted=1` from the next edge.
- `step_done` is high for exactly one cycle, the cycle after the step commits.

## Configuration
- `RUN_CTRL_BP_EN` defined: the breakpoint comparator is present, as described above.
- Not defined: `bp_en` and `bp_addr` remain as ports but are ignored. `stop` reduces to the EBREAK match, and cause 2 never occurs.

## Structure
- Package `run_ctrl_pkg` holds:
  - `cmd_op_t` (RUN/HALT/STEP/CLR)
  - `run_state_t`
  - `halt_cause_t`
  - `EBREAK_INSN = 32'h00100073`
- Sub-module `run_ctrl_stop_detect` is combinational. It takes `pc`, `instruction`, `bp_en`, `bp_addr` and `skip`, and produces `stop` and a cause. The `RUN_CTRL_BP_EN` guard lives inside it.

## Test plan
- BOOT_HALTED=1, release reset: `core_en=0`, `halted=1`, cause 0. Issue STEP: one commit, `retire_cnt=1`, `step_done` pulses, cause 4.
- RUN with `bp_en=1`, `bp_addr=32'h10`, PC stepping by 4: `core_en` drops in the cycle PC=0x10, then `halted=1`, cause 2, `retire_cnt=4`. RUN again: 0x10 commits and no re-halt occurs.
- `instruction=32'h00100073` while RUNNING: halts with cause 3. STEP executes the EBREAK, and the next PC is +4.
- HALT and a breakpoint hit in the same cycle: cause 2, no commit at the breakpoint PC, `cmd_ready` stays 1.
- CLR while RUNNING: ignored and the count keeps rising. CLR while HALTED: `retire_cnt=0`. Counter at CNT_W=4 after 16 commits: wraps to 0.
- Assert `reset` low during STEP: `core_en` drops immediately, and all outputs take their reset values.
